// File: rtl/vm_multi_if.sv
// rtl/vm_multi_if.sv - keypad/coin front end to vending core bundle
interface vm_multi_if #(
    parameter int ITEM_W  = 2,
    parameter int PRICE_W = 8
);
    logic              sel_valid;
    logic [ITEM_W-1:0] sel;
    logic [1:0]        coin;
    logic              cancel;
    logic              restock;

    logic               dispense_valid;
    logic [ITEM_W-1:0]  dispense_item;
    logic               change_valid;
    logic [1:0]         change_coin;
    logic               coin_reject;
    logic               sel_reject;
    logic [PRICE_W-1:0] credit;
    logic               busy;

    modport master (
        output sel_valid, sel, coin, cancel, restock,
        input  dispense_valid, dispense_item, change_valid, change_coin,
        input  coin_reject, sel_reject, credit, busy
    );

    modport slave (
        input  sel_valid, sel, coin, cancel, restock,
        output dispense_valid, dispense_item, change_valid, change_coin,
        output coin_reject, sel_reject, credit, busy
    );
endinterface

// File: rtl/vm_multi.sv
// rtl/vm_multi.sv - N-item vending core with credit, stock and serial change payout
// Optional VM_COIN20_EN: coin/change code 11 means Rs20.
module vm_multi #(
    parameter int                         NUM_ITEMS  = 4,
    parameter int                         ITEM_W     = 2,
    parameter int                         PRICE_W    = 8,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES   = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                         CREDIT_MAX = 50,
    parameter int                         STOCK_W    = 4,
    parameter int                         STOCK_INIT = 8
) (
    input  logic     clk,
    input  logic     reset,
    vm_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t             state_q;
    logic [PRICE_W-1:0] credit_q;
    logic [PRICE_W-1:0] remain_q;
    logic [ITEM_W-1:0]  item_q;
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic               dispense_valid_q;
    logic [ITEM_W-1:0]  dispense_item_q;
    logic               change_valid_q;
    logic [1:0]         change_coin_q;
    logic               coin_reject_q;
    logic               sel_reject_q;

    logic [PRICE_W-1:0] price_cur;
    logic               sel_ok;
    logic [PRICE_W:0]   coin_val;
    logic [PRICE_W:0]   credit_sum_d;
    logic               coin_ok;
    logic [PRICE_W-1:0] vend_remain_d;
    logic [PRICE_W-1:0] change_src;
    logic [1:0]         change_code_d;
    logic [PRICE_W-1:0] change_rest_d;

    function automatic logic [1:0] pick_coin(input logic [PRICE_W-1:0] r);
        logic [1:0] c;
        c = (r >= PRICE_W'(10)) ? 2'b10 : 2'b01;
`ifdef VM_COIN20_EN
        if (r >= PRICE_W'(20)) c = 2'b11;
`endif
        return c;
    endfunction

    function automatic logic [PRICE_W-1:0] coin_value(input logic [1:0] c);
        logic [PRICE_W-1:0] v;
        case (c)
            2'b01:   v = PRICE_W'(5);
            2'b10:   v = PRICE_W'(10);
            2'b11:   v = PRICE_W'(20);
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        price_cur = '0;
        sel_ok    = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_q == ITEM_W'(i)) price_cur = PRICES[i*PRICE_W +: PRICE_W];
            if (bus.sel == ITEM_W'(i) && stock_q[i] != '0) sel_ok = 1'b1;
        end
    end

    always_comb begin
        coin_val = '0;
        case (bus.coin)
            2'b01:   coin_val = (PRICE_W+1)'(5);
            2'b10:   coin_val = (PRICE_W+1)'(10);
`ifdef VM_COIN20_EN
            2'b11:   coin_val = (PRICE_W+1)'(20);
`endif
            default: coin_val = '0;
        endcase
        credit_sum_d = {1'b0, credit_q} + coin_val;
        coin_ok      = (coin_val != '0) && (credit_sum_d <= (PRICE_W+1)'(CREDIT_MAX));
    end

    // Change outputs are registered on the edge that enters/stays in CHANGE, so
    // remain_q always holds what is left after the coin currently on the outputs.
    always_comb begin
        vend_remain_d = credit_q - price_cur;
        case (state_q)
            CHANGE:  change_src = remain_q;
            VEND:    change_src = vend_remain_d;
            default: change_src = credit_q;
        endcase
        change_code_d = pick_coin(change_src);
        change_rest_d = change_src - coin_value(change_code_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            credit_q         <= '0;
            remain_q         <= '0;
            item_q           <= '0;
            dispense_valid_q <= 1'b0;
            dispense_item_q  <= '0;
            change_valid_q   <= 1'b0;
            change_coin_q    <= 2'b00;
            coin_reject_q    <= 1'b0;
            sel_reject_q     <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            dispense_valid_q <= 1'b0;
            change_valid_q   <= 1'b0;
            change_coin_q    <= 2'b00;
            coin_reject_q    <= 1'b0;
            sel_reject_q     <= 1'b0;
            case (state_q)
                IDLE, COLLECT: begin
                    if (state_q == IDLE && bus.restock) begin
                        for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
                    end
                    if (bus.cancel) begin
                        coin_reject_q <= (bus.coin != 2'b00);
                        credit_q      <= '0;
                        item_q        <= '0;
                        if (credit_q != '0) begin
                            state_q        <= CHANGE;
                            change_valid_q <= 1'b1;
                            change_coin_q  <= change_code_d;
                            remain_q       <= change_rest_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (bus.coin != 2'b00) begin
                            if (coin_ok) credit_q <= credit_sum_d[PRICE_W-1:0];
                            else         coin_reject_q <= 1'b1;
                        end
                        // A successful reselection postpones the vend so the new price is re-evaluated.
                        if (bus.sel_valid && sel_ok) begin
                            item_q  <= bus.sel;
                            state_q <= COLLECT;
                        end else begin
                            sel_reject_q <= bus.sel_valid;
                            if (state_q == COLLECT && credit_q >= price_cur) begin
                                state_q          <= VEND;
                                dispense_valid_q <= 1'b1;
                                dispense_item_q  <= item_q;
                            end
                        end
                    end
                end
                VEND: begin
                    coin_reject_q <= (bus.coin != 2'b00);
                    credit_q      <= '0;
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        if (item_q == ITEM_W'(i) && stock_q[i] != '0) stock_q[i] <= stock_q[i] - STOCK_W'(1);
                    end
                    if (vend_remain_d != '0) begin
                        state_q        <= CHANGE;
                        change_valid_q <= 1'b1;
                        change_coin_q  <= change_code_d;
                        remain_q       <= change_rest_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    coin_reject_q <= (bus.coin != 2'b00);
                    if (remain_q != '0) begin
                        change_valid_q <= 1'b1;
                        change_coin_q  <= change_code_d;
                        remain_q       <= change_rest_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.dispense_valid = dispense_valid_q;
    assign bus.dispense_item  = dispense_item_q;
    assign bus.change_valid   = change_valid_q;
    assign bus.change_coin    = change_coin_q;
    assign bus.coin_reject    = coin_reject_q;
    assign bus.sel_reject     = sel_reject_q;
    assign bus.credit         = credit_q;
    assign bus.busy           = (state_q == VEND) || (state_q == CHANGE);
endmodule

// File: tb/tb_vm_multi.sv
// tb/tb_vm_multi.sv - directed self-checking bench for vm_multi
module tb_vm_multi;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    vm_multi_if #(.ITEM_W(3), .PRICE_W(8)) bus ();

    vm_multi #(.NUM_ITEMS(4), .ITEM_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [2:0] s, input logic [1:0] c,
                         input logic cn, input logic rs);
        bus.sel_valid = sv;
        bus.sel       = s;
        bus.coin      = c;
        bus.cancel    = cn;
        bus.restock   = rs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_chg [5];
        int n_disp;
        reset = 1'b1;
        drive(0, 0, 2'b00, 0, 0);
        step();
        reset = 1'b0;
        check("rst_credit", bus.credit, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_disp", bus.dispense_valid, 0);
        check("rst_item", bus.dispense_item, 0);
        check("rst_chg", bus.change_valid, 0);
        check("rst_coin", bus.change_coin, 0);
        check("rst_crej", bus.coin_reject, 0);
        check("rst_srej", bus.sel_reject, 0);

        // item 1 costs 15, paid exactly
        drive(1, 1, 2'b00, 0, 0); step();
        drive(0, 0, 2'b10, 0, 0); step();
        check("t1_credit10", bus.credit, 10);
        drive(0, 0, 2'b01, 0, 0); step();
        check("t1_credit15", bus.credit, 15);
        check("t1_nodisp", bus.dispense_valid, 0);
        drive(0, 0, 2'b00, 0, 0); step();
        check("t1_disp", bus.dispense_valid, 1);
        check("t1_item", bus.dispense_item, 1);
        check("t1_busy", bus.busy, 1);
        step();
        check("t1_credit0", bus.credit, 0);
        check("t1_nochg", bus.change_valid, 0);
        check("t1_idle", bus.busy, 0);

        // item 0 costs 10; second coin arrives in the vend-trigger cycle
        drive(1, 0, 2'b00, 0, 0); step();
        drive(0, 0, 2'b10, 0, 0); step();
        drive(0, 0, 2'b10, 0, 0); step();
        check("t2_disp", bus.dispense_valid, 1);
        check("t2_item", bus.dispense_item, 0);
        check("t2_credit20", bus.credit, 20);
        check("t2_crej", bus.coin_reject, 0);
        drive(0, 0, 2'b00, 0, 0); step();
        check("t2_chg", bus.change_valid, 1);
        check("t2_coin", bus.change_coin, 2'b10);
        check("t2_credit0", bus.credit, 0);
        step();
        check("t2_chg_end", bus.change_valid, 0);
        check("t2_idle", bus.busy, 0);

        // over-limit coin, then cancel refund of 45
        for (int i = 0; i < 4; i++) begin drive(0, 0, 2'b10, 0, 0); step(); end
        drive(0, 0, 2'b01, 0, 0); step();
        check("t3_credit45", bus.credit, 45);
        drive(0, 0, 2'b10, 0, 0); step();
        check("t3_crej", bus.coin_reject, 1);
        check("t3_credit_kept", bus.credit, 45);
        exp_chg = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        drive(0, 0, 2'b00, 1, 0); step();
        drive(0, 0, 2'b00, 0, 0);
        check("t3_credit0", bus.credit, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_chg_v%0d", i), bus.change_valid, 1);
            check($sformatf("t3_chg_c%0d", i), bus.change_coin, exp_chg[i]);
            step();
        end
        check("t3_chg_end", bus.change_valid, 0);
        check("t3_idle", bus.busy, 0);

        // drain item 2 (price 20)
        n_disp = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 2, 2'b10, 0, 0); step();
            drive(0, 0, 2'b10, 0, 0); step();
            drive(0, 0, 2'b00, 0, 0); step();
            if (bus.dispense_valid === 1'b1 && bus.dispense_item === 3'd2) n_disp++;
            step();
        end
        check("t4_dispensed", n_disp, 8);
        drive(1, 2, 2'b00, 0, 0); step();
        check("t4_empty_rej", bus.sel_reject, 1);
        drive(1, 7, 2'b00, 0, 0); step();
        check("t4_range_rej", bus.sel_reject, 1);
        drive(0, 0, 2'b00, 0, 1); step();
        check("t4_rej_pulse", bus.sel_reject, 0);
        drive(1, 2, 2'b00, 0, 0); step();
        check("t4_restock_ok", bus.sel_reject, 0);
        drive(0, 0, 2'b00, 1, 0); step();
        check("t4_cancel_nochg", bus.change_valid, 0);
        drive(0, 0, 2'b00, 0, 0); step();
        check("t4_idle", bus.busy, 0);

        // cancel beats same-cycle coin; coin during change rejected
        drive(1, 3, 2'b00, 0, 0); step();
        drive(0, 0, 2'b10, 0, 0); step();
        check("t5_credit10", bus.credit, 10);
        drive(0, 0, 2'b01, 1, 0); step();
        check("t5_crej", bus.coin_reject, 1);
        check("t5_chg", bus.change_valid, 1);
        check("t5_coin", bus.change_coin, 2'b10);
        check("t5_credit0", bus.credit, 0);
        drive(0, 0, 2'b01, 0, 0); step();
        check("t5_crej_chg", bus.coin_reject, 1);
        check("t5_chg_end", bus.change_valid, 0);
        check("t5_credit_still0", bus.credit, 0);

        // reset in the middle of a 30 refund
        drive(0, 0, 2'b10, 0, 0); step(); step(); step();
        check("t5_credit30", bus.credit, 30);
        drive(0, 0, 2'b00, 1, 0); step();
        drive(0, 0, 2'b00, 0, 0); step();
        check("t5_mid_chg", bus.change_valid, 1);
        reset = 1'b1; step();
        reset = 1'b0;
        check("t5_rst_chg", bus.change_valid, 0);
        check("t5_rst_coin", bus.change_coin, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_credit", bus.credit, 0);
        step();
        check("t5_post_chg", bus.change_valid, 0);
        check("t5_post_busy", bus.busy, 0);
        drive(0, 0, 2'b01, 0, 0); step();
        check("t5_idle_coin", bus.credit, 5);

        reset = 1'b1; drive(0, 0, 2'b00, 0, 0); step();
        reset = 1'b0;
`ifdef VM_COIN20_EN
        drive(1, 0, 2'b11, 0, 0); step();
        check("t6_credit20", bus.credit, 20);
        drive(0, 0, 2'b11, 0, 0); step();
        check("t6_disp", bus.dispense_valid, 1);
        check("t6_credit40", bus.credit, 40);
        drive(0, 0, 2'b00, 0, 0); step();
        check("t6_chg20", bus.change_coin, 2'b11);
        step();
        check("t6_chg10", bus.change_coin, 2'b10);
        step();
        check("t6_chg_end", bus.change_valid, 0);
`else
        drive(1, 0, 2'b11, 0, 0); step();
        check("t6_crej11", bus.coin_reject, 1);
        check("t6_credit0", bus.credit, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vm_multi.md
Name: vm_multi

Overview:
- Parametrised successor to the two-item vending FSM: N items with per-item prices and stock counters, and a credit accumulator.
- Change is paid out serially, one coin per cycle.
- Sits between the coin acceptor / keypad front end and the dispense / coin-hopper actuators.
- All outputs are registered.

Parameters:
NUM_ITEMS, 4, number of selectable items (2..16)
ITEM_W, 2, width of item index; must be >= clog2(NUM_ITEMS)
PRICE_W, 8, width of prices, credit and change remainder
PRICES, {8'd25,8'd20,8'd15,8'd10}, packed NUM_ITEMS*PRICE_W price table in rupees, item 0 in the LSBs; each price a multiple of 5 and nonzero
CREDIT_MAX, 50, maximum credit held; must be < 2**PRICE_W
STOCK_W, 4, width of each stock counter
STOCK_INIT, 8, stock loaded per item at reset and restock

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
sel_valid  in  1  item selection strobe
sel  in  ITEM_W  item index
coin  in  2  coin insert: 00 none, 01 Rs5, 10 Rs10, 11 invalid
cancel  in  1  abort transaction and refund credit
restock  in  1  reload all stock counters to STOCK_INIT
dispense_valid  out  1  one-cycle pulse, item dispensed
dispense_item  out  ITEM_W  index of dispensed item, valid with dispense_valid
change_valid  out  1  one change coin emitted this cycle
change_coin  out  2  01 Rs5, 10 Rs10; 00 when change_valid low
coin_reject  out  1  pulse: coin returned unaccepted
sel_reject  out  1  pulse: selection refused
credit  out  PRICE_W  current accumulated credit
busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (synchronous, priority over all inputs; a transaction in progress is discarded, no refund):
  - State IDLE, credit 0, no item selected.
  - All stock counters = STOCK_INIT.
  - All pulse outputs 0, change_coin 00, dispense_item 0.
- States: IDLE, COLLECT, VEND, CHANGE.
- Coins, accepted only in IDLE/COLLECT:
  - Accepted if credit+value <= CREDIT_MAX; credit updates on the next edge.
  - Otherwise coin_reject=1 on the next cycle and credit is unchanged.
  - coin=11 is always rejected.
  - Any nonzero coin in VEND/CHANGE is rejected.
  - Coins in IDLE keep the FSM in IDLE; pre-paying before selection is allowed.
- Selection, in IDLE/COLLECT:
  - Accepted if sel < NUM_ITEMS and stock[sel] != 0: latch item, go to COLLECT.
  - Otherwise sel_reject pulse and the state/selection are unchanged.
  - Reselection in COLLECT replaces the item.
  - Selection in VEND/CHANGE is ignored with no reject.
- COLLECT:
  - When registered credit >= PRICES[item], the FSM moves to VEND on the next edge.
  - Coin, selection and cancel inputs arriving in that same cycle follow the other rules (a coin in that cycle is still accepted/rejected).
- VEND (exactly 1 cycle):
  - dispense_valid=1, dispense_item=item.
  - stock[item] decrements.
  - Remainder = credit - price is latched; credit is cleared to 0.
  - Next state is CHANGE if remainder != 0, else IDLE.
- CHANGE:
  - One coin per cycle, largest denomination first: Rs10 while remainder >= 10, else Rs5.
  - Remainder decrements by the coin value.
  - Exit to IDLE after the cycle that emits the last coin.
  - Example: remainder 15 gives Rs10 then Rs5 over 2 cycles.
- Cancel in IDLE/COLLECT:
  - Remainder = credit, credit cleared, selection cleared.
  - Go to CHANGE if remainder != 0, else IDLE.
  - Cancel outranks a same-cycle coin (the coin is rejected) and a same-cycle selection (ignored).
  - Cancel in VEND/CHANGE is ignored.
- Restock: applied only in IDLE, and ignored otherwise.
- Stock counters saturate at 0 and are never decremented below it.
- busy=1 exactly in VEND and CHANGE.

Optional Feature:
- Macro: VM_COIN20_EN.
- Defined:
  - coin=11 means Rs20, subject to the same CREDIT_MAX check.
  - Change adds change_coin=11 (Rs20), used first while remainder >= 20.
- Undefined: coin=11 is always rejected, and change is paid in Rs10/Rs5 only.

Test Plan:
- Reset, sel=1, coin Rs10 then Rs5 -> credit 10 then 15; one dispense_valid with item 1; no change; stock[1]=7; back to IDLE.
- sel=0, coin Rs10, Rs10 (second coin lands on the VEND-trigger cycle, credit 20) -> dispense item 0, then change_valid with Rs10 for 1 cycle, then IDLE.
- Coins to credit 45, then Rs10 -> coin_reject pulse, credit stays 45; cancel -> change Rs10 x4 then Rs5 over 5 consecutive cycles; credit 0.
- Drain item 2 with 8 purchases, then sel=2 -> sel_reject; sel=7 with NUM_ITEMS=4 -> sel_reject; restock in IDLE -> sel=2 accepted.
- cancel and coin Rs5 in the same cycle in COLLECT with credit 10 -> coin_reject, refund Rs10; coin during CHANGE -> coin_reject; reset mid-CHANGE -> outputs 0, IDLE next cycle.
- VM_COIN20_EN: sel=0, coin 11 then 11 -> credit 40, dispense item 0, change Rs20 then Rs10; without the macro, coin 11 -> coin_reject.
